video_fetch_sequencer: RTL and testbench

- Sequences the 2-bit-per-shift video data shift register for one active scanline.
- Fetches display bytes from video memory over a req/ack handshake, holding one byte in a prefetch buffer.
- Generates the load strobe and byte to the shift register at a fixed 4-shift cadence, and advances the line address per scanline.
- Sits between the display timing generator (line_start/frame_start) and the shift register/memory arbiter.

---
 rtl/video_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_video_fetch_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_sequencer.sv
// Purpose : fetches one scanline of display bytes over req/ack and loads the 2-bit shift register.
// Latency : first load window opens 3P clks after line_start; line_done pulses 1 clk after the last window.
// Backpressure: a single outstanding read; a slot with no byte ready loads 0x00 and sets sticky underflow.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   frame_start         frame pulse: reload line address from base_addr, clear line count and underflow
//   line_start          scanline pulse: start (or abort and restart) a line fetch; div2 sampled here
//   base_addr, div2     frame base address, slow pixel mode (shift period 2 clks)
//   mem_req/addr        read request, address held until mem_ack
//   mem_ack/data        read completion with data
//   load, load_data     shift register load strobe (one shift period wide) and byte
//   line_done           pulse after the final load window of a line
//   underflow           sticky: a load slot found no byte ready
module video_fetch_sequencer #(
  parameter int BYTES_PER_LINE = 32,
  parameter int ACTIVE_LINES   = 192,
  parameter int ADDR_WIDTH     = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  div2,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  load,
  output logic [7:0]            load_data,
  output logic                  line_done,
  output logic                  underflow
);

  localparam int                    CNT_W     = $clog2(ACTIVE_LINES + 1);
  localparam logic [CNT_W-1:0]      LINES_MAX = CNT_W'(ACTIVE_LINES);
  localparam logic [7:0]            BPL       = 8'(BYTES_PER_LINE);
  localparam logic [ADDR_WIDTH-1:0] BPL_A     = ADDR_WIDTH'(BYTES_PER_LINE);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic [CNT_W-1:0]      r_line_cnt;
  logic [ADDR_WIDTH-1:0] r_byte_addr;
  logic [7:0]            r_bytes_left;
  logic [7:0]            r_fetch_left;
  logic [2:0]            r_phase;
  logic                  r_div2;
  logic [7:0]            r_buf;
  logic                  r_buf_vld;
  logic                  r_req;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_discard;
  logic [7:0]            r_load_data;
  logic                  r_line_done;
  logic                  r_underflow;

  logic                  w_active;
  logic                  w_ack;
  logic                  w_take;
  logic [2:0]            w_last_ph;
  logic [2:0]            w_slot_ph;
  logic [2:0]            w_win_ph;
  logic                  w_abort;
  logic                  w_end;
  logic                  w_run;
  logic                  w_slot;
  logic                  w_adv;
  logic [ADDR_WIDTH-1:0] w_la0;
  logic [ADDR_WIDTH-1:0] w_la1;
  logic [CNT_W-1:0]      w_lc0;
  logic [CNT_W-1:0]      w_lc1;
  logic                  w_start;
  logic                  w_buf_vld_nxt;
  logic [7:0]            w_fetch_left_nxt;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic                  w_issue;

  assign w_active  = (r_state == S_ACTIVE);
  // Acks are only meaningful while our request is up; data from a request
  // that belongs to a previous line/frame is dropped via r_discard.
  assign w_ack     = mem_ack & r_req;
  assign w_take    = w_ack & ~r_discard;

  // Phase runs 0..4P-1; the slot decision is made on the clock before the
  // window opens so load_data is registered for the whole window.
  assign w_last_ph = r_div2 ? 3'd7 : 3'd3;
  assign w_slot_ph = r_div2 ? 3'd5 : 3'd2;
  assign w_win_ph  = r_div2 ? 3'd6 : 3'd3;

  assign w_abort   = line_start & ~frame_start & w_active;
  assign w_end     = w_active & ~frame_start & ~line_start &
                     (r_phase == w_last_ph) & (r_bytes_left == 8'd0);
  assign w_run     = w_active & ~frame_start & ~line_start & ~w_end;
  assign w_slot    = w_run & (r_phase == w_slot_ph);
  assign w_adv     = w_abort | w_end;

  // frame_start takes effect first, then any line advance, then a new start
  // is judged against the resulting line count.
  assign w_la0     = frame_start ? base_addr : r_line_addr;
  assign w_lc0     = frame_start ? '0 : r_line_cnt;
  assign w_la1     = w_adv ? (w_la0 + BPL_A) : w_la0;
  assign w_lc1     = w_adv ? (w_lc0 + CNT_W'(1)) : w_lc0;
  assign w_start   = line_start & (w_lc1 < LINES_MAX);

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ACTIVE;
    end else if (frame_start) begin
      w_state_nxt = S_IDLE;
    end else if (w_adv) begin
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Buffer occupancy after this clock. A slot with an empty buffer but an
  // ack in the same cycle forwards mem_data straight to load_data.
  always_comb begin
    w_buf_vld_nxt = 1'b0;
    if (w_run) begin
      if (w_slot) begin
        w_buf_vld_nxt = r_buf_vld & w_take;
      end else begin
        w_buf_vld_nxt = r_buf_vld | w_take;
      end
    end
  end

  assign w_fetch_left_nxt = w_start ? BPL : r_fetch_left;
  assign w_issue_addr     = w_start ? w_la1 : r_byte_addr;
  // New requests wait for mem_req to have dropped, so there is always a gap
  // of at least one clock between requests.
  assign w_issue          = (w_state_nxt == S_ACTIVE) & ~r_req & ~w_buf_vld_nxt &
                            (w_fetch_left_nxt != 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_addr  <= '0;
      r_line_cnt   <= '0;
      r_byte_addr  <= '0;
      r_bytes_left <= '0;
      r_fetch_left <= '0;
      r_phase      <= '0;
      r_div2       <= 1'b0;
      r_buf        <= '0;
      r_buf_vld    <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_discard    <= 1'b0;
      r_load_data  <= '0;
      r_line_done  <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_line_addr <= w_la1;
      r_line_cnt  <= w_lc1;
      r_line_done <= w_end;
      r_buf_vld   <= w_buf_vld_nxt;
      if (w_take) begin
        r_buf <= mem_data;
      end

      if (w_start) begin
        r_div2       <= div2;
        r_phase      <= 3'd1;
        r_bytes_left <= BPL;
      end else if (w_run) begin
        r_phase <= (r_phase == w_last_ph) ? 3'd0 : (r_phase + 3'd1);
        if (w_slot) begin
          r_bytes_left <= r_bytes_left - 8'd1;
        end
      end

      if (w_slot) begin
        if (r_buf_vld) begin
          r_load_data <= r_buf;
        end else if (w_take) begin
          r_load_data <= mem_data;
        end else begin
          r_load_data <= 8'h00;
        end
      end

      if (frame_start) begin
        r_underflow <= 1'b0;
      end else if (w_slot & ~r_buf_vld & ~w_take) begin
        r_underflow <= 1'b1;
      end

      if (w_ack) begin
        r_discard <= 1'b0;
      end else if ((frame_start | w_start) & r_req) begin
        r_discard <= 1'b1;
      end

      if (w_ack) begin
        r_req <= 1'b0;
      end
      if (w_start) begin
        r_byte_addr  <= w_la1;
        r_fetch_left <= BPL;
      end
      if (w_issue) begin
        r_req        <= 1'b1;
        r_addr       <= w_issue_addr;
        r_byte_addr  <= w_issue_addr + ADDR_WIDTH'(1);
        r_fetch_left <= w_fetch_left_nxt - 8'd1;
      end
    end
  end

  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign load      = w_active & (r_phase >= w_win_ph);
  assign load_data = r_load_data;
  assign line_done = r_line_done;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_video_fetch_sequencer.sv
// Purpose : randomized and directed bench for video_fetch_sequencer against a timeline reference model.
// Latency : each step covers one clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: memory ack latency chosen per request, spurious acks injected while idle.
module tb_video_fetch_sequencer;

  localparam int BPL = 4;
  localparam int AL  = 2;
  localparam int AW  = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          line_start;
  logic [AW-1:0] base_addr;
  logic          div2;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_data;
  logic          load;
  logic [7:0]    load_data;
  logic          line_done;
  logic          underflow;

  always #5 clk = ~clk;

  video_fetch_sequencer #(
    .BYTES_PER_LINE(BPL),
    .ACTIVE_LINES  (AL),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .line_start (line_start),
    .base_addr  (base_addr),
    .div2       (div2),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .load       (load),
    .load_data  (load_data),
    .line_done  (line_done),
    .underflow  (underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line is a timeline t = clks since line_start; it lasts
  // 4P*BPL clks, windows are t mod 4P in [3P,4P), a slot decision is taken
  // the clk before each window opens.
  bit         m_active, m_req, m_discard, m_uf, m_done;
  int         m_t, m_p, m_line_addr, m_line_cnt, m_base, m_idx, m_addr;
  logic [7:0] m_ld;
  logic [7:0] m_buf_q[$];

  // memory responder and event log
  int  fixed_lat, lat_max, req_age, cur_lat;
  bit  spurious_en;
  int  rel;
  int  q_load_t[$];
  int  q_load_d[$];
  int  q_addr[$];
  int  done_t[$];
  bit  prev_load, prev_req;

  task automatic model_reset();
    m_active = 0; m_req = 0; m_discard = 0; m_uf = 0; m_done = 0;
    m_t = 0; m_p = 0; m_line_addr = 0; m_line_cnt = 0; m_base = 0; m_idx = 0; m_addr = 0;
    m_ld = 8'h00;
    m_buf_q.delete();
    req_age = 0; prev_load = 0; prev_req = 0;
  endtask

  task automatic clear_log();
    q_load_t.delete(); q_load_d.delete(); q_addr.delete(); done_t.delete();
  endtask

  task automatic step(input bit fs, input bit ls, input bit d2, input logic [AW-1:0] base);
    bit         exp_load, ack, ackv, take, ended, aborted, cont, start, old_req;
    logic [7:0] dat;
    rel++;
    exp_load = 1'b0;
    if (m_active) exp_load = ((m_t % (4 * m_p)) >= 3 * m_p);
    check_val("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) check_val("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_val("load", 32'(load), 32'(exp_load));
    if (exp_load) check_val("load_data", 32'(load_data), 32'(m_ld));
    check_val("line_done", 32'(line_done), 32'(m_done));
    check_val("underflow", 32'(underflow), 32'(m_uf));
    if (load && !prev_load) begin q_load_t.push_back(rel); q_load_d.push_back(int'(load_data)); end
    if (mem_req && !prev_req) q_addr.push_back(int'(mem_addr));
    if (line_done) done_t.push_back(rel);
    prev_load = load;
    prev_req  = mem_req;

    ack = 1'b0;
    dat = 8'($urandom);
    if (m_req) begin
      if (req_age == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, lat_max);
      if (req_age == cur_lat) begin
        ack = 1'b1;
        dat = 8'(m_addr);
      end
      req_age++;
    end else begin
      req_age = 0;
      if (spurious_en && $urandom_range(0, 5) == 0) ack = 1'b1;
    end
    frame_start = fs; line_start = ls; div2 = d2; base_addr = base;
    mem_ack = ack; mem_data = dat;
    if (ls) rel = 0;

    ackv    = ack && m_req;
    take    = ackv && !m_discard;
    old_req = m_req;
    if (ackv) begin m_req = 0; m_discard = 0; end
    ended   = m_active && !fs && !ls && (m_t == 4 * m_p * BPL - 1);
    aborted = m_active && ls && !fs;
    cont    = m_active && !fs && !ls && !ended;
    m_done  = ended;
    if (fs) begin m_line_addr = int'(base); m_line_cnt = 0; m_uf = 0; m_active = 0; end
    if (ended || aborted) begin
      m_line_addr = (m_line_addr + BPL) % (1 << AW);
      m_line_cnt++;
      m_active = 0;
    end
    start = ls && (m_line_cnt < AL);
    if ((fs || start) && old_req && !ackv) m_discard = 1;
    if (start) begin
      m_active = 1; m_t = 1; m_p = d2 ? 2 : 1; m_base = m_line_addr; m_idx = 0;
      m_buf_q.delete();
    end else if (cont) begin
      if (((m_t + 1) % (4 * m_p)) == 3 * m_p) begin
        if (m_buf_q.size() > 0) m_ld = m_buf_q.pop_front();
        else if (take) begin m_ld = dat; take = 0; end
        else begin m_ld = 8'h00; m_uf = 1; end
      end
      if (take) m_buf_q.push_back(dat);
      m_t++;
    end else begin
      m_buf_q.delete();
    end
    if (m_active && !old_req && m_buf_q.size() == 0 && m_idx < BPL) begin
      m_req = 1; m_addr = (m_base + m_idx) % (1 << AW); m_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), AW'($urandom));
  endtask

  task automatic check_loads(input string tag, input int t0, input int dt);
    check_val({tag, "_nloads"}, 32'(q_load_t.size()), 32'(BPL));
    for (int i = 0; i < BPL && i < q_load_t.size(); i++) begin
      check_val({tag, "_load_t"}, 32'(q_load_t[i]), 32'(t0 + i * dt));
      check_val({tag, "_load_d"}, 32'(q_load_d[i]), 32'(i));
    end
  endtask

  initial begin
    int countdown;
    reset = 1'b1; frame_start = 0; line_start = 0; div2 = 0; base_addr = '0;
    mem_ack = 0; mem_data = '0;
    fixed_lat = 1; lat_max = 3; spurious_en = 0; rel = 0;
    model_reset();
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_load", 32'(load), 32'd0);
    check_val("rst_load_data", 32'(load_data), 32'd0);
    check_val("rst_line_done", 32'(line_done), 32'd0);
    check_val("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;

    // 1: div2=0, latency 1
    step(1, 0, 0, 13'h0100); clear_log();
    step(0, 1, 0, '0); idle(20);
    check_val("s1_naddr", 32'(q_addr.size()), 32'(BPL));
    for (int i = 0; i < BPL && i < q_addr.size(); i++) check_val("s1_addr", 32'(q_addr[i]), 32'(13'h0100 + i));
    check_loads("s1", 3, 4);
    check_val("s1_ndone", 32'(done_t.size()), 32'd1);
    if (done_t.size() > 0) check_val("s1_done_t", 32'(done_t[0]), 32'd16);
    check_val("s1_underflow", 32'(underflow), 32'd0);

    // 2: div2=1
    step(1, 0, 0, 13'h0100); clear_log();
    step(0, 1, 1, '0); idle(36);
    check_loads("s2", 6, 8);
    check_val("s2_ndone", 32'(done_t.size()), 32'd1);
    if (done_t.size() > 0) check_val("s2_done_t", 32'(done_t[0]), 32'd32);

    // 3: latency 6 -> underflow, cleared by frame_start
    fixed_lat = 6;
    step(1, 0, 0, 13'h0100); clear_log();
    step(0, 1, 0, '0); idle(18);
    if (q_load_d.size() > 0) check_val("s3_first_data", 32'(q_load_d[0]), 32'd0);
    check_val("s3_underflow_set", 32'(underflow), 32'd1);
    step(1, 0, 0, 13'h0000);
    check_val("s3_underflow_clr", 32'(underflow), 32'd0);
    idle(8);

    // 4: address wrap across two lines
    fixed_lat = 1;
    step(1, 0, 0, 13'h1FFE); clear_log();
    step(0, 1, 0, '0); idle(17);
    step(0, 1, 0, '0); idle(17);
    check_val("s4_naddr", 32'(q_addr.size()), 32'(2 * BPL));
    if (q_addr.size() > 4) begin
      check_val("s4_wrap_in_line", 32'(q_addr[2]), 32'h0000);
      check_val("s4_line2_first", 32'(q_addr[4]), 32'h0002);
    end

    // 5: abort after two loads
    step(1, 0, 0, 13'h0200); clear_log();
    step(0, 1, 0, '0); idle(8);
    check_val("s5_loads_before", 32'(q_load_t.size()), 32'd2);
    clear_log();
    step(0, 1, 0, '0); idle(12);
    check_val("s5_no_done", 32'(done_t.size()), 32'd0);
    if (q_addr.size() > 0) check_val("s5_next_addr", 32'(q_addr[0]), 32'h0204);
    else check_val("s5_next_addr_seen", 32'd0, 32'd1);
    idle(10);

    // 7: line limit, third line_start ignored
    step(1, 0, 0, 13'h0000);
    step(0, 1, 0, '0); idle(17);
    step(0, 1, 0, '0); idle(17);
    clear_log();
    step(0, 1, 0, '0); idle(20);
    check_val("s7_no_req", 32'(q_addr.size()), 32'd0);
    check_val("s7_no_load", 32'(q_load_t.size()), 32'd0);

    // 6: async reset in the middle of a request
    fixed_lat = 8;
    step(1, 0, 0, 13'h0300);
    step(0, 1, 0, '0); idle(3);
    check_val("s6_req_up", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    frame_start = 0; line_start = 0; mem_ack = 1'b1; mem_data = 8'hFF;
    #1;
    check_val("s6_mem_req", 32'(mem_req), 32'd0);
    check_val("s6_mem_addr", 32'(mem_addr), 32'd0);
    check_val("s6_load", 32'(load), 32'd0);
    check_val("s6_load_data", 32'(load_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    spurious_en = 1;
    idle(10);
    check_val("s6_req_after", 32'(mem_req), 32'd0);

    // randomized traffic
    fixed_lat = -1;
    countdown = 5;
    for (int c = 0; c < 4000; c++) begin
      bit fs, ls;
      if (c % 500 == 0) lat_max = $urandom_range(0, 9);
      fs = ($urandom_range(0, 60) == 0);
      ls = (countdown == 0);
      countdown = ls ? $urandom_range(4, 45) : countdown - 1;
      step(fs, ls, 1'($urandom), AW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
